// File: rtl/ppi_pkg.sv
// ppi_pkg: shared state encoding and register constants
// for the 8255A CPU-side bus sequencer.
package ppi_pkg;

  typedef enum logic [2:0] {
    ST_INIT_SETUP,
    ST_INIT_STROBE,
    ST_INIT_HOLD,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } ppi_state_e;

  localparam logic [1:0] PPI_ADDR_PA   = 2'd0;
  localparam logic [1:0] PPI_ADDR_PB   = 2'd1;
  localparam logic [1:0] PPI_ADDR_PC   = 2'd2;
  localparam logic [1:0] PPI_ADDR_CTRL = 2'd3;

  localparam logic [7:0] PPI_CTRL_ALL_OUT = 8'h80;

endpackage

// File: rtl/ppi_phase_timer.sv
// ppi_phase_timer: 4-bit phase down-counter, loaded on
// each phase entry, flags its last cycle and idle state.
module ppi_phase_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] val_i,
  output logic       zero_o,
  output logic       last_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == 4'd0);
  assign last_o = (cnt_q == 4'd1);

endmodule

// File: rtl/ppi_bus_master.sv
// ppi_bus_master: drives the 8255A CPU bus from a
// request/response port, with a post-reset control write.
module ppi_bus_master
  import ppi_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter bit          INIT_EN    = 1'b1,
  parameter logic [7:0]  INIT_CTRL  = PPI_CTRL_ALL_OUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       nCS,
  output logic       nRD,
  output logic       nWR,
  output logic [1:0] A,
  output logic [7:0] Dout,
  output logic       DEn,
  input  logic [7:0] Din
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15 ||
      STROBE_CYC < 1 || STROBE_CYC > 15 ||
      HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_param
    $error("ppi_bus_master: phase lengths must be 1..15");
  end

  localparam logic [3:0] S4 = 4'(SETUP_CYC);
  localparam logic [3:0] P4 = 4'(STROBE_CYC);
  localparam logic [3:0] H4 = 4'(HOLD_CYC);

  ppi_state_e state_q;
  logic       ncs_q, nrd_q, nwr_q, den_q;
  logic [1:0] a_q;
  logic [7:0] dout_q, rdata_q;
  logic       rsp_valid_q, ready_q, busy_q, wr_q;

  logic       t_load, t_zero, t_last;
  logic [3:0] t_val;
  logic       accept;

  assign accept = (state_q == ST_IDLE) && req_valid && ready_q;

  always_comb begin
    t_load = 1'b0;
    t_val  = S4;
    unique case (state_q)
      ST_INIT_SETUP, ST_SETUP: begin
        t_load = t_zero | t_last;
        t_val  = t_zero ? S4 : P4;
      end
      ST_INIT_STROBE, ST_STROBE: begin
        t_load = t_last;
        t_val  = H4;
      end
      ST_IDLE: t_load = accept;
      ST_INIT_HOLD, ST_HOLD: t_load = 1'b0;
      default: t_load = 1'b0;
    endcase
  end

  ppi_phase_timer u_timer (
    .clk_i  (clk),
    .rst_i  (reset),
    .load_i (t_load),
    .val_i  (t_val),
    .zero_o (t_zero),
    .last_o (t_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT_EN ? ST_INIT_SETUP : ST_IDLE;
      ncs_q       <= 1'b1;
      nrd_q       <= 1'b1;
      nwr_q       <= 1'b1;
      den_q       <= 1'b0;
      a_q         <= 2'd0;
      dout_q      <= 8'd0;
      rdata_q     <= 8'd0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      wr_q        <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        ST_INIT_SETUP: begin
          // Zero count marks the first cycle out of reset.
          if (t_zero) begin
            ncs_q  <= 1'b0;
            a_q    <= PPI_ADDR_CTRL;
            dout_q <= INIT_CTRL;
            den_q  <= 1'b1;
          end else if (t_last) begin
            state_q <= ST_INIT_STROBE;
            nwr_q   <= 1'b0;
          end
        end
        ST_INIT_STROBE: begin
          if (t_last) begin
            state_q <= ST_INIT_HOLD;
            nwr_q   <= 1'b1;
          end
        end
        ST_INIT_HOLD, ST_HOLD: begin
          if (t_last) begin
            state_q     <= ST_IDLE;
            ncs_q       <= 1'b1;
            den_q       <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= (state_q == ST_HOLD);
          end
        end
        ST_IDLE: begin
          ready_q <= !accept;
          busy_q  <= accept;
          if (accept) begin
            state_q <= ST_SETUP;
            wr_q    <= req_wr;
            ncs_q   <= 1'b0;
            a_q     <= req_addr;
            den_q   <= req_wr;
            if (req_wr) dout_q <= req_wdata;
          end
        end
        ST_SETUP: begin
          if (t_last) begin
            state_q <= ST_STROBE;
            nwr_q   <= !wr_q;
            nrd_q   <= wr_q;
          end
        end
        ST_STROBE: begin
          if (t_last) begin
            state_q <= ST_HOLD;
            nwr_q   <= 1'b1;
            nrd_q   <= 1'b1;
            if (!wr_q) rdata_q <= Din;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign busy      = busy_q;
  assign nCS       = ncs_q;
  assign nRD       = nrd_q;
  assign nWR       = nwr_q;
  assign A         = a_q;
  assign Dout      = dout_q;
  assign DEn       = den_q;

endmodule
